serial_adder: RTL and testbench

Bit-serial ripple adder that computes A + B + Cin over WIDTH clock cycles, LSB first. It uses one full-adder cell and a registered carry. It is the addition counterpart to the combinational full subtractor and is intended for area-constrained datapaths where one bit per clock is acceptable. A start/busy/done handshake makes it drop-in for a simple sequencer.

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: computes a + b + cin one bit per clock, LSB first,
// using a single full-adder cell and a registered carry.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] op_a, op_a_d;
  logic [WIDTH-1:0] op_b, op_b_d;
  logic [WIDTH-1:0] res, res_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             carry, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, done_d, busy_d;

  logic             s_bit, maj, last;
  logic [WIDTH-1:0] res_nx;

  // Full-adder cell on the current LSBs; the new sum bit enters the result MSB
  assign s_bit  = op_a[0] ^ op_b[0] ^ carry;
  assign maj    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign res_nx = (res >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      op_a  <= op_a_d;
      op_b  <= op_b_d;
      res   <= res_d;
      cnt   <= cnt_d;
      carry <= carry_d;
      sum   <= sum_d;
      cout  <= cout_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  // Next-state and datapath; DONE accepts start exactly like IDLE for back-to-back use
  always_comb begin
    state_d = state;
    op_a_d  = op_a;
    op_b_d  = op_b;
    res_d   = res;
    cnt_d   = cnt;
    carry_d = carry;
    sum_d   = sum;
    cout_d  = cout;
    done_d  = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        op_a_d  = op_a >> 1;
        op_b_d  = op_b >> 1;
        carry_d = maj;
        res_d   = res_nx;
        cnt_d   = cnt + CW'(1);
        if (last) begin
          sum_d   = res_nx;
          cout_d  = maj;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start1, a1, b1, cin1;
  logic       busy1, done1, sum1, cout1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit add, wait (bounded) for done, check latency and result
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int n;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, pulses, busy_low;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic add with SHIFT-phase observation
    a = 8'h3C; b = 8'h05; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_done_low", 32'(done), 32'd0);
      check("t1_sum_hold", 32'(sum), 32'd0);
      tick();
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_sum", 32'(sum), 32'h41);
    check("t1_cout", 32'(cout), 32'd0);
    tick();
    check("t1_done_drop", 32'(done), 32'd0);

    // 2: carry boundaries
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("t2c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // 3: start during SHIFT is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      if (n == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      else start = 1'b0;
      tick();
      n++;
    end while (!done && n < 20);
    start = 1'b0;
    check("t3_lat", 32'(n), 32'd8);
    check("t3_sum", 32'(sum), 32'h30);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("t3_no_retrigger", 32'(pulses), 32'd0);

    // 4: back-to-back with start held high
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    n = 0; busy_low = 0;
    do begin
      if (!busy) busy_low++;
      tick();
      n++;
    end while (!done && n < 20);
    check("t4_lat1", 32'(n), 32'd8);
    check("t4_busy1", 32'(busy_low), 32'd0);
    check("t4_sum1", 32'(sum), 32'h02);
    check("t4_busy_done", 32'(busy), 32'd0);
    a = 8'h02; b = 8'h03;
    n = 0; busy_low = 0;
    do begin
      tick();
      n++;
      if (!busy && !done) busy_low++;
    end while (!done && n < 20);
    start = 1'b0;
    check("t4_spacing", 32'(n), 32'd9);
    check("t4_busy2", 32'(busy_low), 32'd0);
    check("t4_sum2", 32'(sum), 32'h05);
    tick();
    check("t4_done_drop", 32'(done), 32'd0);

    // 5: asynchronous reset mid-operation
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    #10 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'd0);
    check("t5_sum_hold", 32'(sum), 32'd0);
    run_op("t5_new", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // 6: WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("t6_busy", 32'(busy1), 32'd1);
      check("t6_early", 32'(done1), 32'd0);
      tick();
      check("t6_done", 32'(done1), 32'd1);
      check("t6_result", 32'({cout1, sum1}), 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
